// File: rtl/hex_scan_display.sv
// hex_scan_display: multiplexed common-anode hex display driver with per-frame snapshot,
// anti-ghost dead time, PWM brightness and leading-zero blanking.
module hex_scan_display #(
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 50000,
    parameter int DEAD     = 64,
    parameter int BRIGHT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);
    localparam int DW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int SW = $clog2(SCAN_DIV);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t              state;
    logic [SW-1:0]       slot_cnt, slot_nx;
    logic [DW-1:0]       dig_idx;
    logic [BRIGHT_W-1:0] pwm_cnt;
    logic [4*DIGITS-1:0] sh_data;
    logic [DIGITS-1:0]   sh_dp, lz;
    logic                sh_blz, init, wrap, frame_end, lit, dark;
    logic [3:0]          nib;
    logic [6:0]          hex;

    // lz[k]: nibbles k..DIGITS-1 of the snapshot are all zero
    for (genvar k = 0; k < DIGITS; k++) begin : g_lz
        assign lz[k] = ~|sh_data[4*DIGITS-1:4*k];
    end

    always_comb begin
        wrap      = slot_cnt == SW'(SCAN_DIV - 1);
        frame_end = wrap && dig_idx == DW'(DIGITS - 1);
        slot_nx   = wrap ? '0 : slot_cnt + 1'b1;
        nib       = sh_data[4*dig_idx +: 4];
        lit       = bright == '1 || pwm_cnt < bright;
        dark      = sh_blz && lz[dig_idx] && dig_idx != '0;
    end

    always_comb begin
        case (nib)
            4'h0: hex = 7'h3F;
            4'h1: hex = 7'h06;
            4'h2: hex = 7'h5B;
            4'h3: hex = 7'h4F;
            4'h4: hex = 7'h66;
            4'h5: hex = 7'h6D;
            4'h6: hex = 7'h7D;
            4'h7: hex = 7'h07;
            4'h8: hex = 7'h7F;
            4'h9: hex = 7'h6F;
            4'hA: hex = 7'h77;
            4'hB: hex = 7'h7C;
            4'hC: hex = 7'h39;
            4'hD: hex = 7'h5E;
            4'hE: hex = 7'h79;
            default: hex = 7'h71;
        endcase
    end

    // init holds the counters for one clk after reset so the first snapshot lands on a frame start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= BLANK;
            slot_cnt   <= '0;
            dig_idx    <= '0;
            pwm_cnt    <= '0;
            sh_data    <= '0;
            sh_dp      <= '0;
            sh_blz     <= 1'b0;
            init       <= 1'b1;
            frame_tick <= 1'b0;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            an         <= '1;
        end else begin
            pwm_cnt    <= pwm_cnt + 1'b1;
            init       <= 1'b0;
            frame_tick <= init || frame_end;
            if (init || frame_end) begin
                sh_data <= data_in;
                sh_dp   <= dp_in;
                sh_blz  <= blank_lz;
            end
            if (!init) begin
                slot_cnt <= slot_nx;
                state    <= slot_nx >= SW'(DEAD) ? DRIVE : BLANK;
                if (wrap) dig_idx <= frame_end ? '0 : dig_idx + 1'b1;
            end
            an  <= state == DRIVE && lit ? ~(DIGITS'(1) << dig_idx) : '1;
            seg <= state == DRIVE && !dark ? ~hex : 7'h7F;
            dp  <= !(state == DRIVE && !dark && sh_dp[dig_idx]);
        end
    end
endmodule

// File: tb/tb_hex_scan_display.sv
// tb_hex_scan_display: table-driven frame checks of hex_scan_display plus reset, anti-tearing
// and mid-frame reset sequences.
module tb_hex_scan_display;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [1:0] dp_in = 2'b00;
    logic       blank_lz = 1'b0;
    logic [3:0] bright = 4'hF;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] an;
    logic       frame_tick;
    int         compared = 0;
    int         mismatched = 0;
    int         cyc = 0;

    typedef struct {
        logic [7:0] data;
        logic [1:0] dpi;
        logic       blz;
        logic [3:0] br;
        logic [6:0] seg0;
        logic [6:0] seg1;
        logic       dp0;
        logic       dp1;
    } vec_t;

    vec_t tbl[12];
    vec_t va, vb;

    hex_scan_display #(.DIGITS(2), .SCAN_DIV(8), .DEAD(2), .BRIGHT_W(4)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .blank_lz(blank_lz),
        .bright(bright), .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // clk edges since the last reset release; pwm phase at sample k is (k-1) mod 16
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int p, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s p=%0d cyc=%0d: got %h, expected %h", name, p, cyc, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        data_in  = v.data;
        dp_in    = v.dpi;
        blank_lz = v.blz;
        bright   = v.br;
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 40);
        if (!frame_tick) begin
            mismatched++;
            $display("FAIL wait_tick: no frame_tick within 40 clk");
        end
    endtask

    // samples the 16 clk following a frame_tick; optionally changes data_in mid digit-0 slot
    task automatic check_frame(input vec_t v, input bit chg, input logic [7:0] nd);
        for (int p = 0; p < 16; p++) begin
            int  slot, dig, pw;
            bit  drv, lt;
            @(negedge clk);
            if (chg && p == 3) data_in = nd;
            slot = p % 8;
            dig  = p / 8;
            drv  = slot >= 2;
            pw   = (cyc - 1) & 15;
            lt   = v.br == 4'hF || pw < int'(v.br);
            chk("an", p, {6'd0, an}, drv && lt ? (dig == 1 ? 8'h01 : 8'h02) : 8'h03);
            chk("seg", p, {1'b0, seg}, drv ? {1'b0, dig == 1 ? v.seg1 : v.seg0} : 8'h7F);
            chk("dp", p, {7'd0, dp}, drv ? {7'd0, dig == 1 ? v.dp1 : v.dp0} : 8'h01);
            chk("frame_tick", p, {7'd0, frame_tick}, p == 15 ? 8'h01 : 8'h00);
        end
    endtask

    initial begin
        tbl[0]  = '{8'hA5, 2'b01, 1'b0, 4'hF, 7'h12, 7'h08, 1'b0, 1'b1};
        tbl[1]  = '{8'h3C, 2'b00, 1'b0, 4'hF, 7'h46, 7'h30, 1'b1, 1'b1};
        tbl[2]  = '{8'h07, 2'b10, 1'b1, 4'hF, 7'h78, 7'h7F, 1'b1, 1'b1};
        tbl[3]  = '{8'h00, 2'b00, 1'b1, 4'hF, 7'h40, 7'h7F, 1'b1, 1'b1};
        tbl[4]  = '{8'h00, 2'b00, 1'b0, 4'hF, 7'h40, 7'h40, 1'b1, 1'b1};
        tbl[5]  = '{8'h80, 2'b00, 1'b1, 4'hF, 7'h40, 7'h00, 1'b1, 1'b1};
        tbl[6]  = '{8'hBE, 2'b11, 1'b0, 4'hF, 7'h06, 7'h03, 1'b0, 1'b0};
        tbl[7]  = '{8'hD9, 2'b00, 1'b0, 4'hF, 7'h10, 7'h21, 1'b1, 1'b1};
        tbl[8]  = '{8'h3C, 2'b01, 1'b0, 4'h4, 7'h46, 7'h30, 1'b0, 1'b1};
        tbl[9]  = '{8'h3C, 2'b00, 1'b0, 4'h0, 7'h46, 7'h30, 1'b1, 1'b1};
        tbl[10] = '{8'h3C, 2'b00, 1'b0, 4'h1, 7'h46, 7'h30, 1'b1, 1'b1};
        tbl[11] = '{8'hF6, 2'b00, 1'b1, 4'hE, 7'h02, 7'h0E, 1'b1, 1'b1};
        va      = '{8'h12, 2'b00, 1'b0, 4'hF, 7'h24, 7'h79, 1'b1, 1'b1};
        vb      = '{8'h34, 2'b00, 1'b0, 4'hF, 7'h19, 7'h30, 1'b1, 1'b1};

        apply(tbl[0]);
        repeat (3) @(negedge clk);
        chk("rst_seg", -1, {1'b0, seg}, 8'h7F);
        chk("rst_dp", -1, {7'd0, dp}, 8'h01);
        chk("rst_an", -1, {6'd0, an}, 8'h03);
        chk("rst_tick", -1, {7'd0, frame_tick}, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        chk("first_tick", -1, {7'd0, frame_tick}, 8'h01);
        check_frame(tbl[0], 1'b0, 8'h00);

        for (int i = 1; i < 12; i++) begin
            apply(tbl[i]);
            wait_tick();
            check_frame(tbl[i], 1'b0, 8'h00);
        end

        apply(va);
        wait_tick();
        check_frame(va, 1'b1, 8'h34);
        check_frame(vb, 1'b0, 8'h00);

        apply(tbl[1]);
        wait_tick();
        repeat (11) @(negedge clk);
        chk("pre_rst_an", -1, {6'd0, an}, 8'h01);
        #2 rst = 1'b0;
        #1;
        chk("midrst_an", -1, {6'd0, an}, 8'h03);
        chk("midrst_seg", -1, {1'b0, seg}, 8'h7F);
        chk("midrst_dp", -1, {7'd0, dp}, 8'h01);
        chk("midrst_tick", -1, {7'd0, frame_tick}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rerun_tick", -1, {7'd0, frame_tick}, 8'h01);
        check_frame(tbl[1], 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
